rps_draw_sequencer: RTL and testbench

- Sequences the 160x120 VGA framebuffer writes for one rock-paper-scissors round.
- Optionally clears the screen, then draws the user's sprite in the left slot and the computer's sprite in the right slot.
- Drives the shared sprite ROM (address plus select) and the vga_adapter x/y/colour/plot inputs, one pixel per clock.
- Pixel coordinates are delay-matched to the ROM read latency so every plotted colour belongs to its own x/y.

---
 rtl/rps_draw_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_rps_draw_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rps_draw_sequencer.sv
// Round-draw sequencer for the 160x120 VGA framebuffer: optional full-screen
// clear, then the user sprite (left slot) and the computer sprite (right slot),
// one pixel per clock. The sprite ROM is addressed one cycle ahead of the
// issuing scan counters. The ROM data then lands exactly when the delayed
// x/y/kind reaches the registered output stage, so every plotted colour
// belongs to its own coordinate.
//
// Handshake: start is sampled only while dbg_state is IDLE; a start seen in any
// other state is dropped, never queued. busy is high from the cycle after an
// accepted start through the last plot; done pulses high for exactly one cycle
// with busy low; plot is a single-cycle write strobe qualified by x/y/colour.
module rps_draw_sequencer #(
  parameter int         SPRITE_W     = 64,
  parameter int         SPRITE_H     = 64,
  parameter int         ADDR_W       = 12,
  parameter int         ROM_LAT      = 1,
  parameter int         USER_X       = 8,
  parameter int         CPU_X        = 88,
  parameter int         SPR_Y        = 28,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000,
  parameter logic [2:0] USER_FG      = 3'b000,
  parameter logic [2:0] USER_BG      = 3'b010,
  parameter logic [2:0] CPU_FG       = 3'b111,
  parameter logic [2:0] CPU_BG       = 3'b010
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic              clear_en,
  input  logic [1:0]        user_sel,
  input  logic [1:0]        cpu_sel,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [1:0]        rom_sel,
  input  logic              rom_q,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    DRAW_U = 3'd2,
    DRAW_C = 3'd3,
    FLUSH  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [1:0] KIND_CLEAR = 2'd0;
  localparam logic [1:0] KIND_USER  = 2'd1;
  localparam logic [1:0] KIND_CPU   = 2'd2;

  localparam logic [7:0]        SCR_LAST_COL = 8'd159;
  localparam logic [6:0]        SCR_LAST_ROW = 7'd119;
  localparam logic [7:0]        SPR_LAST_COL = 8'(SPRITE_W - 1);
  localparam logic [6:0]        SPR_LAST_ROW = 7'(SPRITE_H - 1);
  localparam logic [7:0]        UX           = 8'(USER_X);
  localparam logic [7:0]        CX           = 8'(CPU_X);
  localparam logic [6:0]        SY           = 7'(SPR_Y);
  localparam logic [1:0]        FLUSH_LAST   = 2'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);

  typedef struct packed {
    logic       v;
    logic [1:0] kind;
    logic [7:0] x;
    logic [6:0] y;
  } pix_t;

  // Codes 1x both select the paper bank.
  function automatic logic [1:0] map_sel(input logic [1:0] s);
    return s[1] ? 2'b10 : s;
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        col_q, col_d;
  logic [6:0]        row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        usel_q, usel_d;
  logic [1:0]        csel_q, csel_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic [7:0]        last_col;
  logic [6:0]        last_row;
  pix_t              issue_pix;
  pix_t              tail;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [2:0]        colour_q;
  logic              plot_q;

  // Sequencer state, scan counters and latched selections.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      usel_q  <= '0;
      csel_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      usel_q  <= usel_d;
      csel_q  <= csel_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state: raster scans chain CLEAR -> DRAW_U -> DRAW_C with no bubble.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    usel_d   = usel_q;
    csel_d   = csel_q;
    fcnt_d   = fcnt_q;
    last_col = (state_q == CLEAR) ? SCR_LAST_COL : SPR_LAST_COL;
    last_row = (state_q == CLEAR) ? SCR_LAST_ROW : SPR_LAST_ROW;
    case (state_q)
      IDLE: begin
        col_d  = '0;
        row_d  = '0;
        addr_d = '0;
        fcnt_d = '0;
        if (start) begin
          usel_d  = map_sel(user_sel);
          csel_d  = map_sel(cpu_sel);
          state_d = clear_en ? CLEAR : DRAW_U;
        end
      end
      CLEAR, DRAW_U, DRAW_C: begin
        addr_d = (state_q == CLEAR) ? '0 : addr_q + ADDR_ONE;
        if (col_q == last_col) begin
          col_d = '0;
          if (row_q == last_row) begin
            row_d   = '0;
            addr_d  = '0;
            state_d = (state_q == DRAW_C) ? FLUSH :
                      (state_q == CLEAR)  ? DRAW_U : DRAW_C;
          end else begin
            row_d = row_q + 7'd1;
          end
        end else begin
          col_d = col_q + 8'd1;
        end
      end
      FLUSH: begin
        if (fcnt_q == FLUSH_LAST) state_d = DONE;
        else                      fcnt_d  = fcnt_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ROM is addressed with the pixel the counters will issue next cycle.
  always_comb begin
    rom_addr = '0;
    rom_sel  = 2'b00;
    if (state_d == DRAW_U) begin
      rom_addr = addr_d;
      rom_sel  = usel_d;
    end else if (state_d == DRAW_C) begin
      rom_addr = addr_d;
      rom_sel  = csel_d;
    end
  end

  // Pixel issued this cycle by the scan counters.
  always_comb begin
    issue_pix      = '0;
    issue_pix.v    = (state_q == CLEAR) || (state_q == DRAW_U) || (state_q == DRAW_C);
    issue_pix.kind = (state_q == DRAW_U) ? KIND_USER :
                     (state_q == DRAW_C) ? KIND_CPU  : KIND_CLEAR;
    issue_pix.x    = (state_q == DRAW_U) ? UX + col_q :
                     (state_q == DRAW_C) ? CX + col_q : col_q;
    issue_pix.y    = (state_q == CLEAR)  ? row_q : SY + row_q;
  end

  generate
    if (ROM_LAT == 1) begin : g_direct
      assign tail = issue_pix;
    end else begin : g_chain
      pix_t mid_q [ROM_LAT-1];
      // Coordinate delay line matching the extra ROM latency.
      always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < ROM_LAT - 1; i++) mid_q[i] <= '0;
        end else begin
          mid_q[0] <= issue_pix;
          for (int i = 1; i < ROM_LAT - 1; i++) mid_q[i] <= mid_q[i-1];
        end
      end
      assign tail = mid_q[ROM_LAT-2];
    end
  endgenerate

  // Final chain stage: x/y/colour/plot registered together, held when idle.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      plot_q <= tail.v;
      if (tail.v) begin
        x_q <= tail.x;
        y_q <= tail.y;
        case (tail.kind)
          KIND_USER: colour_q <= rom_q ? USER_FG : USER_BG;
          KIND_CPU:  colour_q <= rom_q ? CPU_FG : CPU_BG;
          default:   colour_q <= CLEAR_COLOUR;
        endcase
      end
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign busy      = (state_q == CLEAR) || (state_q == DRAW_U) ||
                     (state_q == DRAW_C) || (state_q == FLUSH);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rps_draw_sequencer.sv
// Bench for rps_draw_sequencer: two instances (ROM latency 1 and 3) share the
// stimulus; each has its own ROM model and expected-pixel queue.
module tb_rps_draw_sequencer;

  localparam int AW    = 12;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          start, clear_en;
  logic [1:0]    user_sel, cpu_sel;
  logic [AW-1:0] rom_addr_a, rom_addr_b;
  logic [1:0]    rom_sel_a, rom_sel_b;
  logic          rom_q_a, rom_q_b;
  logic [7:0]    x_a, x_b;
  logic [6:0]    y_a, y_b;
  logic [2:0]    colour_a, colour_b;
  logic          plot_a, plot_b, busy_a, busy_b, done_a, done_b;
  logic [2:0]    dbg_a, dbg_b;

  rps_draw_sequencer #(.ROM_LAT(LAT_A)) dut_a (
    .CLOCK_50(clk), .reset_n(rst_n), .start(start), .clear_en(clear_en),
    .user_sel(user_sel), .cpu_sel(cpu_sel), .rom_addr(rom_addr_a),
    .rom_sel(rom_sel_a), .rom_q(rom_q_a), .x(x_a), .y(y_a),
    .colour(colour_a), .plot(plot_a), .busy(busy_a), .done(done_a),
    .dbg_state(dbg_a)
  );

  rps_draw_sequencer #(.ROM_LAT(LAT_B)) dut_b (
    .CLOCK_50(clk), .reset_n(rst_n), .start(start), .clear_en(clear_en),
    .user_sel(user_sel), .cpu_sel(cpu_sel), .rom_addr(rom_addr_b),
    .rom_sel(rom_sel_b), .rom_q(rom_q_b), .x(x_b), .y(y_b),
    .colour(colour_b), .plot(plot_b), .busy(busy_b), .done(done_b),
    .dbg_state(dbg_b)
  );

  // ---------------- ROM model ----------------
  // Each bank holds a different bit pattern so a wrong bank select shows up.
  function automatic logic rom_val(input logic [1:0] s, input logic [AW-1:0] a);
    case (s)
      2'b00:   return a[0];
      2'b01:   return a[1] ^ a[6];
      2'b10:   return a[3] ^ a[8] ^ a[0];
      default: return ~a[0];
    endcase
  endfunction

  logic       rq_a;
  logic [2:0] rq_b;
  always @(posedge clk) begin
    rq_a <= rom_val(rom_sel_a, rom_addr_a);
    rq_b <= {rq_b[1:0], rom_val(rom_sel_b, rom_addr_b)};
  end
  assign rom_q_a = rq_a;
  assign rom_q_b = rq_b[2];

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q_a[$];
  logic [17:0] exp_q_b[$];
  int pidx[2];
  bit active[2];
  bit seen_done[2];
  int exp_n = 0;
  int acc = 0;
  int total = 0;
  int bad = 0;

  // Choice -> ROM bank: rock, scissor, paper (both 1x codes mean paper).
  function automatic logic [1:0] bank(input logic [1:0] choice);
    if (choice == 2'b00) return 2'b00;
    if (choice == 2'b01) return 2'b01;
    return 2'b10;
  endfunction

  // Reference: the full ordered list of plots for one round.
  task automatic build_expect(input bit clr, input logic [1:0] us, input logic [1:0] cs);
    logic [17:0] e;
    logic        q;
    logic [2:0]  c;
    exp_q_a.delete();
    exp_q_b.delete();
    if (clr) begin
      for (int r = 0; r < 120; r++)
        for (int cl = 0; cl < 160; cl++) begin
          e = {8'(cl), 7'(r), 3'b000};
          exp_q_a.push_back(e);
          exp_q_b.push_back(e);
        end
    end
    for (int who = 0; who < 2; who++)
      for (int r = 0; r < 64; r++)
        for (int cl = 0; cl < 64; cl++) begin
          q = rom_val(bank(who == 1 ? cs : us), AW'(r * 64 + cl));
          if (who == 1) c = q ? 3'b111 : 3'b010;
          else          c = q ? 3'b000 : 3'b010;
          e = {8'((who == 1 ? 88 : 8) + cl), 7'(28 + r), c};
          exp_q_a.push_back(e);
          exp_q_b.push_back(e);
        end
    exp_n = exp_q_a.size();
  endtask

  task automatic check_inst(input int i, input logic p, input logic [7:0] xx,
                            input logic [6:0] yy, input logic [2:0] cc,
                            input logic d, input logic b, input int lat);
    int rel;
    logic [17:0] e, got;
    bit empty;
    rel = cyc - acc + 1;
    if (p === 1'b1) begin
      total++;
      got = {xx, yy, cc};
      empty = (i == 0) ? (exp_q_a.size() == 0) : (exp_q_b.size() == 0);
      if (empty) begin
        bad++;
        $display("FAIL unexpected_plot inst=%0d got=(%0d,%0d,c%0d) cycle=%0d required=no plot",
                 i, xx, yy, cc, rel);
      end else begin
        if (i == 0) e = exp_q_a.pop_front();
        else        e = exp_q_b.pop_front();
        if (got !== e || rel != 1 + lat + pidx[i]) begin
          bad++;
          $display("FAIL plot inst=%0d n=%0d got=(%0d,%0d,c%0d)@%0d required=(%0d,%0d,c%0d)@%0d",
                   i, pidx[i], xx, yy, cc, rel, e[17:10], e[9:3], e[2:0], 1 + lat + pidx[i]);
        end
        pidx[i]++;
      end
    end
    if (d === 1'b1) begin
      total++;
      if (!active[i] || rel != exp_n + lat + 1 || pidx[i] != exp_n || b !== 1'b0) begin
        bad++;
        $display("FAIL done inst=%0d active=%0d cycle=%0d plots=%0d busy=%b required cycle=%0d plots=%0d busy=0",
                 i, active[i], rel, pidx[i], b, exp_n + lat + 1, exp_n);
      end
      active[i]    = 1'b0;
      seen_done[i] = 1'b1;
    end
  endtask

  // Monitor: pops and compares whenever an instance plots or signals done.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check_inst(0, plot_a, x_a, y_a, colour_a, done_a, busy_a, LAT_A);
      check_inst(1, plot_b, x_b, y_b, colour_b, done_b, busy_b, LAT_B);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero();
    logic [AW+25:0] va, vb;
    va = {rom_addr_a, rom_sel_a, x_a, y_a, colour_a, plot_a, busy_a, done_a};
    vb = {rom_addr_b, rom_sel_b, x_b, y_b, colour_b, plot_b, busy_b, done_b};
    total++;
    if (va !== '0 || vb !== '0) begin
      bad++;
      $display("FAIL async_clear got a=%h b=%h required=0", va, vb);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero();
    exp_q_a.delete();
    exp_q_b.delete();
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0;
      pidx[i]   = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      total++;
      if ({plot_a, plot_b, busy_a, busy_b, done_a, done_b} !== 6'b0) begin
        bad++;
        $display("FAIL idle_after_reset got plot=%b%b busy=%b%b done=%b%b required=0",
                 plot_a, plot_b, busy_a, busy_b, done_a, done_b);
      end
    end
  endtask

  task automatic run_round(input bit clr, input logic [1:0] us, input logic [1:0] cs,
                           input int abort_at, input bit poke);
    int rel;
    int limit;
    @(negedge clk);
    total++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL idle_before_start got busy=%b%b required=00", busy_a, busy_b);
    end
    build_expect(clr, us, cs);
    for (int i = 0; i < 2; i++) begin
      pidx[i]      = 0;
      active[i]    = 1'b1;
      seen_done[i] = 1'b0;
    end
    start    = 1'b1;
    clear_en = clr;
    user_sel = us;
    cpu_sel  = cs;
    @(posedge clk);
    #1;
    acc      = cyc;
    start    = 1'b0;
    clear_en = 1'($urandom);
    user_sel = 2'($urandom);
    cpu_sel  = 2'($urandom);
    limit    = exp_n + 20;
    rel      = 1;
    while (!(seen_done[0] && seen_done[1]) && rel <= limit) begin
      @(negedge clk);
      rel = cyc - acc + 1;
      if (rel == 1) begin
        total++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
          bad++;
          $display("FAIL busy_start got busy=%b%b required=11", busy_a, busy_b);
        end
      end
      if (poke && rel >= 100 && rel < 300 && (rel % 37) == 0) begin
        start    = 1'b1;
        clear_en = 1'($urandom);
        user_sel = 2'($urandom);
        cpu_sel  = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      if (abort_at != 0 && rel == abort_at) begin
        start = 1'b0;
        apply_reset();
        return;
      end
    end
    start = 1'b0;
    total++;
    if (!(seen_done[0] && seen_done[1])) begin
      bad++;
      $display("FAIL round_timeout got done=%0d%0d required=11 within %0d cycles",
               seen_done[0], seen_done[1], limit);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    clear_en = 1'b0;
    user_sel = 2'b00;
    cpu_sel  = 2'b00;
    repeat (2) @(posedge clk);
    apply_reset();
    // basic round: rock vs scissor, no clear
    run_round(1'b0, 2'b00, 2'b01, 0, 1'b0);
    // clear round with random choices
    run_round(1'b1, 2'($urandom), 2'($urandom), 0, 1'b0);
    // start pulses and selection changes mid-round; cpu code 11 maps to paper
    run_round(1'b0, 2'($urandom_range(0, 3)), 2'b11, 0, 1'b1);
    // reset in the middle of DRAW_C
    run_round(1'b0, 2'($urandom), 2'($urandom), 6000, 1'b0);
    // normal round after the abort
    run_round(1'b0, 2'($urandom), 2'($urandom), 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
